// File: rtl/alu_wb_fifo.sv
`default_nettype none
// ============================================================================
// alu_wb_fifo : in-order ALU result buffer between the IQ execute handshake
// and the CDB arbiter. Optional same-cycle bypass: ALU_WB_FIFO_BYPASS_EN.
// Rev 1.0
// ============================================================================
module alu_wb_fifo #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic [ROB_ID_W-1:0]      in_rob_id_i,
  output logic                     ready_o,
  output logic                     cdb_valid_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output logic [ROB_ID_W-1:0]      cdb_rob_id_o,
  input  logic                     cdb_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [ROB_ID_W-1:0] rob_mem  [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                not_empty;
  logic                push;
  logic                pop;

  assign not_empty = (count != '0);
  assign ready_o   = (count < FULL_COUNT);
  assign pop       = not_empty & cdb_ready_i;
  assign count_o   = count;

`ifdef ALU_WB_FIFO_BYPASS_EN
  logic bypass;

  // An empty FIFO forwards the incoming result; if taken it is never stored.
  assign bypass = ~not_empty & in_valid_i;
  assign push   = in_valid_i & ready_o & ~(bypass & cdb_ready_i);

  always_comb begin
    cdb_valid_o  = not_empty | bypass;
    cdb_data_o   = '0;
    cdb_rob_id_o = '0;
    if (not_empty) begin
      cdb_data_o   = data_mem[rd_ptr];
      cdb_rob_id_o = rob_mem[rd_ptr];
    end else if (bypass) begin
      cdb_data_o   = in_data_i;
      cdb_rob_id_o = in_rob_id_i;
    end
  end
`else
  assign push         = in_valid_i & ready_o;
  assign cdb_valid_o  = not_empty;
  assign cdb_data_o   = not_empty ? data_mem[rd_ptr] : '0;
  assign cdb_rob_id_o = not_empty ? rob_mem[rd_ptr]  : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr] <= in_data_i;
      rob_mem[wr_ptr]  <= in_rob_id_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_fifo.sv
`default_nettype none
// ============================================================================
// tb_alu_wb_fifo : self-checking bench for alu_wb_fifo against a queue model.
// Rev 1.0
// ============================================================================
module tb_alu_wb_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [5:0]  in_rob = '0;
  logic        cdb_ready = 1'b0;
  logic        ready;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_rob;
  logic [CNT_W-1:0] count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  r;
  } ent_t;
  ent_t q[$];

  alu_wb_fifo #(.DEPTH(DEPTH), .DATA_W(32), .ROB_ID_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_rob_id_i  (in_rob),
    .ready_o      (ready),
    .cdb_valid_o  (cdb_valid),
    .cdb_data_o   (cdb_data),
    .cdb_rob_id_o (cdb_rob),
    .cdb_ready_i  (cdb_ready),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Reference model: a plain queue of accepted results.
  function automatic bit bypass_hit();
`ifdef ALU_WB_FIFO_BYPASS_EN
    return (q.size() == 0) && in_valid;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_valid();
    return (q.size() != 0) || bypass_hit();
  endfunction

  function automatic logic [31:0] exp_data();
    if (q.size() != 0) return q[0].d;
    if (bypass_hit())  return in_data;
    return '0;
  endfunction

  function automatic logic [5:0] exp_rob();
    if (q.size() != 0) return q[0].r;
    if (bypass_hit())  return in_rob;
    return '0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] r,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_rob    = r;
    cdb_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    bit hit, popd, acc;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      hit  = bypass_hit();
      popd = (q.size() > 0) && cdb_ready;
      acc  = in_valid && (q.size() < DEPTH) && !(hit && cdb_ready);
      if (popd) void'(q.pop_front());
      if (acc)  q.push_back('{d: in_data, r: in_rob});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, '0, '0, 0, 0);
    repeat (2) @(negedge clk);
    q.delete();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", cdb_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests++; if (cdb_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", cdb_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h11 * (i + 1), 6'(i + 1), 0, 0);
      tick();
    end
    drive(1, 32'h55, 6'd5, 0, 0);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", count); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b expected 0", ready); end
    tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_ignored: got %0d expected 4", count); end
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, 1, 0);
      tests++;
      if (cdb_valid !== 1'b1 || cdb_data !== 32'h11 * (i + 1) || cdb_rob !== 6'(i + 1)) begin
        fails++;
        $display("FAIL fill_drain[%0d]: got v=%b %h/%0d expected v=1 %h/%0d",
                 i, cdb_valid, cdb_data, cdb_rob, 32'h11 * (i + 1), i + 1);
      end
      tick();
      if (i == 0) begin
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL fill_reopen: got %b expected 1", ready); end
      end
    end
    drive(0, '0, '0, 0, 0);
    tests++; if (cdb_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL fill_empty: got v=%b c=%0d expected v=0 c=0", cdb_valid, count); end
  endtask

  task automatic test_wrap();
    int next_push = 0;
    int max_count = 0;
    int got[$];
    bit ok;
    bit acc;
    for (int cyc = 0; cyc < 80 && got.size() < 10; cyc++) begin
      logic v = (next_push < 10);
      logic rdy = logic'(cyc % 2);
      drive(v, 32'(next_push), 6'(next_push), rdy, 0);
      if (int'(count) > max_count) max_count = int'(count);
      if (cdb_valid && rdy) got.push_back(int'(cdb_data));
      acc = v && (q.size() < DEPTH);
      tick();
      if (acc) next_push++;
    end
    ok = (got.size() == 10);
    for (int i = 0; i < got.size(); i++) if (got[i] != i) ok = 0;
    tests++; if (!ok) begin fails++; $display("FAIL wrap_order: got %0d items expected 0..9 in order", got.size()); end
    tests++; if (max_count > DEPTH) begin fails++; $display("FAIL wrap_max_count: got %0d expected <= %0d", max_count, DEPTH); end
    drive(0, '0, '0, 0, 0);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_empty: got %0d expected 0", count); end
  endtask

  task automatic test_simul();
    drive(1, 32'hA0, 6'd10, 0, 0); tick();
    drive(1, 32'hA1, 6'd11, 1, 0);
    tests++; if (cdb_data !== 32'hA0) begin fails++; $display("FAIL simul1_head: got %h expected a0", cdb_data); end
    tick();
    drive(0, '0, '0, 0, 0);
    tests++; if (count !== 3'd1 || cdb_data !== 32'hA1) begin fails++; $display("FAIL simul1_after: got c=%0d %h expected c=1 a1", count, cdb_data); end
    drive(1, 32'hA2, 6'd12, 0, 0); tick();
    drive(1, 32'hA3, 6'd13, 0, 0); tick();
    drive(1, 32'hA4, 6'd14, 1, 0);
    tests++; if (count !== 3'd3 || cdb_data !== 32'hA1) begin fails++; $display("FAIL simul3_before: got c=%0d %h expected c=3 a1", count, cdb_data); end
    tick();
    drive(0, '0, '0, 0, 0);
    tests++; if (count !== 3'd3 || cdb_data !== 32'hA2 || cdb_rob !== 6'd12) begin fails++; $display("FAIL simul3_after: got c=%0d %h/%0d expected c=3 a2/12", count, cdb_data, cdb_rob); end
    for (int i = 0; i < 3; i++) begin drive(0, '0, '0, 1, 0); tick(); end
    drive(0, '0, '0, 0, 0);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL simul_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    bit seen;
    for (int i = 0; i < 3; i++) begin drive(1, 32'h31 + i, 6'(i), 0, 0); tick(); end
    drive(1, 32'hAA, 6'd42, 0, 1);
    tick();
    drive(0, '0, '0, 0, 0);
    tests++; if (count !== 3'd0 || cdb_valid !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL flush_state: got c=%0d v=%b r=%b expected c=0 v=0 r=1", count, cdb_valid, ready); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, '0, 1, 0);
      if (cdb_valid || cdb_data == 32'hAA) seen = 1;
      tick();
    end
    tests++; if (seen) begin fails++; $display("FAIL flush_leak: got stale output expected none"); end
    drive(1, 32'h01, 6'd1, 0, 0); tick();
    drive(0, '0, '0, 0, 0);
    tests++; if (cdb_data !== 32'h01 || count !== 3'd1) begin fails++; $display("FAIL flush_refill: got %h c=%0d expected 01 c=1", cdb_data, count); end
    drive(0, '0, '0, 1, 0); tick();
  endtask

  task automatic test_bypass();
    drive(1, 32'hBEEF, 6'd7, 1, 0);
`ifdef ALU_WB_FIFO_BYPASS_EN
    tests++; if (cdb_valid !== 1'b1 || cdb_data !== 32'hBEEF || cdb_rob !== 6'd7) begin fails++; $display("FAIL bypass_same: got v=%b %h/%0d expected v=1 beef/7", cdb_valid, cdb_data, cdb_rob); end
    tick();
    drive(0, '0, '0, 0, 0);
    tests++; if (count !== 3'd0 || cdb_valid !== 1'b0) begin fails++; $display("FAIL bypass_after: got c=%0d v=%b expected c=0 v=0", count, cdb_valid); end
`else
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL nobypass_same: got v=%b expected 0", cdb_valid); end
    tick();
    drive(0, '0, '0, 1, 0);
    tests++; if (cdb_valid !== 1'b1 || cdb_data !== 32'hBEEF || cdb_rob !== 6'd7 || count !== 3'd1) begin fails++; $display("FAIL nobypass_next: got v=%b %h/%0d c=%0d expected v=1 beef/7 c=1", cdb_valid, cdb_data, cdb_rob, count); end
    tick();
    drive(0, '0, '0, 0, 0);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL nobypass_drain: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_async_reset();
    drive(1, 32'h77, 6'd3, 0, 0); tick();
    drive(1, 32'h78, 6'd4, 0, 0); tick();
    drive(0, '0, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    tests++; if (count !== 3'd0 || cdb_valid !== 1'b0 || ready !== 1'b1 || cdb_data !== 32'h0) begin fails++; $display("FAIL async_reset: got c=%0d v=%b r=%b d=%h expected 0/0/1/0", count, cdb_valid, ready, cdb_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 6'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 29) == 0);
      tests++; if (cdb_valid !== exp_valid()) begin fails++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, cdb_valid, exp_valid()); end
      tests++; if (cdb_data !== exp_data()) begin fails++; $display("FAIL rnd_data@%0d: got %h expected %h", cyc, cdb_data, exp_data()); end
      tests++; if (cdb_rob !== exp_rob()) begin fails++; $display("FAIL rnd_rob@%0d: got %0d expected %0d", cyc, cdb_rob, exp_rob()); end
      tests++; if (ready !== (q.size() < DEPTH)) begin fails++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, ready, q.size() < DEPTH); end
      tests++; if (count !== CNT_W'(q.size())) begin fails++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, count, q.size()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_simul();
    test_flush();
    test_bypass();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_wb_fifo.md
# alu_wb_fifo

Result buffer at the consumer end of the ALU issue queue's execute handshake. It accepts one completed ALU result per cycle, tagged with its ROB id, while holding `ready_o` (the queue's `fifo_ready`) high. It presents buffered results in order on a valid/ready port toward the CDB arbiter and is emptied on pipeline flush.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `DATA_W`, 32: result width (`word_t`).
- `ROB_ID_W`, 6: ROB tag width (`rob_id_t`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous pipeline flush; discards all entries.
- `in_valid_i`  in  1  result valid from the IQ (`excute_valid_o`).
- `in_data_i`  in  DATA_W  result value (`result_o`).
- `in_rob_id_i`  in  ROB_ID_W  destination ROB tag.
- `ready_o`  out  1  FIFO can accept; drives the IQ's `fifo_ready`.
- `cdb_valid_o`  out  1  head entry valid toward the CDB.
- `cdb_data_o`  out  DATA_W  head result.
- `cdb_rob_id_o`  out  ROB_ID_W  head ROB tag.
- `cdb_ready_i`  in  1  CDB arbiter accepts the head this cycle.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular array of DEPTH entries {data, rob_id}. Read pointer and write pointer are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy counter is $clog2(DEPTH)+1 bits.
- Push = `in_valid_i & ready_o`. On a push, the entry is written at the write pointer and the write pointer increments.
- Pop = `cdb_valid_o & cdb_ready_i`. On a pop, the read pointer increments.
- Count next value = count + push − pop. A simultaneous push and pop leaves the count unchanged, including at count = DEPTH−1 and count = 1.
- `ready_o` = (count < DEPTH). It is a function of registered state only; there is no combinational path from `cdb_ready_i`. When full, a same-cycle pop does not open the input.
- `cdb_valid_o` = (count ≠ 0). `cdb_data_o` and `cdb_rob_id_o` come from the entry at the read pointer. These outputs stay stable while `cdb_valid_o=1 & cdb_ready_i=0`.
- `in_valid_i` while `ready_o=0`: the input is ignored and nothing is written. The IQ holds its data in that case.
- Flush: on the next edge, pointers and count go to 0. Any push or pop in the flush cycle is discarded. Stored data is not cleared.
- Order: strict FIFO; the output order equals the acceptance order.

## Timing
- Reset (asynchronous, `rst_n=0`): count=0, pointers=0, `ready_o=1`, `cdb_valid_o=0`, `count_o=0`. `cdb_data_o` and `cdb_rob_id_o` are forced to 0 while empty.
- Reset asserted mid-operation: all entries are lost immediately. Outputs take their reset values asynchronously.
- Latency without bypass: a result pushed at edge N is visible on `cdb_*` in the cycle after edge N (one cycle minimum).
- Throughput: one push and one pop per cycle sustained.
- `ready_o` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.

## Configuration
- `ALU_WB_FIFO_BYPASS_EN` defined: when count=0 and `in_valid_i=1`, the input drives `cdb_*` combinationally in the same cycle with `cdb_valid_o=1`.
  - If `cdb_ready_i=1` in that cycle, the result is consumed without being written. Count stays 0.
  - Otherwise the result is written normally.
- `ALU_WB_FIFO_BYPASS_EN` undefined: the latency rule in Timing applies; `cdb_valid_o` depends only on registered state.

## Test plan
- Reset then idle: `rst_n` low for 2 cycles → `ready_o=1`, `cdb_valid_o=0`, `count_o=0`.
- Fill without pop: push data 0x11/0x22/0x33/0x44 with rob_id 1..4, `cdb_ready_i=0` → `count_o=4`, `ready_o=0`. A 5th `in_valid_i` (0x55) is ignored. Then `cdb_ready_i=1` → outputs 0x11, 0x22, 0x33, 0x44 in order, and `ready_o=1` after the first pop.
- Wrap-around: 10 sequential pushes of i (0..9), interleaved with pops every other cycle → output order 0..9 with no loss or duplicate; count never exceeds DEPTH.
- Simultaneous push/pop at count=1 and at count=3 → count unchanged; head advances correctly.
- Flush with count=3 while pushing 0xAA in the same cycle → next cycle count=0, `cdb_valid_o=0`; 0xAA never appears.
- Bypass (macro on): empty FIFO, push 0xBEEF/rob 7 with `cdb_ready_i=1` → `cdb_valid_o=1`, `cdb_data_o=0xBEEF` in the same cycle, count stays 0. With the macro off → output appears one cycle later.
